// File: rtl/cpu_run_controller.sv
// cpu_run_controller: sequences a CPU core through a reset hold, a bounded
// or halt-terminated run, and a read-back dump of a memory window.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start, CPU held in reset
// HOLD  | CPU reset held for RESET_HOLD cycles after start
// RUN   | CPU clock enabled, counting cycles until halt or limit
// RD    | controller drives the dump pointer onto the memory address
// CAP   | read data captured into the dump output registers
// OUT   | dump word presented, waiting for dump_ready
// DONE  | run and dump finished, results held until next start
module cpu_run_controller #(
  parameter int N          = 32,
  parameter int ADDR_W     = 10,
  parameter int CYC_W      = 32,
  parameter int RESET_HOLD = 2,
  parameter int DUMP_START = 0,
  parameter int DUMP_STOP  = 256
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  input  logic [CYC_W-1:0]  cycle_limit,
  input  logic              halt,
  output logic              cpu_rst,
  output logic              cpu_clk_en,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [N-1:0]      mem_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [N-1:0]      dump_data,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CYC_W-1:0]  cycles_run
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HOLD = 3'd1,
    RUN  = 3'd2,
    RD   = 3'd3,
    CAP  = 3'd4,
    OUT  = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam int HOLD_W = 16;
  localparam int AW1    = ADDR_W + 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD =
    (RESET_HOLD > 0) ? HOLD_W'(RESET_HOLD - 1) : '0;
  localparam logic [ADDR_W-1:0] PTR_INIT = ADDR_W'(DUMP_START);
  // One extra bit so a window ending exactly at 2^ADDR_W terminates cleanly.
  localparam logic [AW1-1:0] PTR_STOP = AW1'(DUMP_STOP);
  localparam logic HAS_DUMP = (DUMP_STOP > DUMP_START);

  state_t state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [ADDR_W-1:0] ptr;
  logic [CYC_W:0]    run_next;
  logic              limit_hit;
  logic              ptr_last;

  assign run_next  = {1'b0, cycles_run} + 1'b1;
  assign limit_hit = (cycle_limit != '0) && (run_next == {1'b0, cycle_limit});
  assign ptr_last  = (({1'b0, ptr} + 1'b1) == PTR_STOP);

  // State register.
  always_ff @(posedge clk) begin
    if (rstb) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (RESET_HOLD == 0) ? RUN : HOLD;
      HOLD:       if (hold_cnt == '0) state_nxt = RUN;
      RUN:        if (halt || limit_hit) state_nxt = HAS_DUMP ? RD : DONE;
      RD:         state_nxt = CAP;
      CAP:        state_nxt = OUT;
      OUT:        if (dump_ready) state_nxt = ptr_last ? DONE : RD;
      default:    state_nxt = IDLE;
    endcase
  end

  // Counters, run result and dump capture registers.
  always_ff @(posedge clk) begin
    if (rstb) begin
      hold_cnt   <= '0;
      ptr        <= '0;
      cycles_run <= '0;
      timeout    <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cycles_run <= '0;
            timeout    <= 1'b0;
            hold_cnt   <= HOLD_LOAD;
          end
        end
        HOLD: begin
          if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
        end
        RUN: begin
          if (cycles_run != '1) cycles_run <= cycles_run + 1'b1;
          // Halt wins over the limit when both land on the same cycle.
          if (!halt && limit_hit) timeout <= 1'b1;
          if (halt || limit_hit) ptr <= PTR_INIT;
        end
        CAP: begin
          dump_data <= mem_rd_data;
          dump_addr <= ptr;
        end
        OUT: begin
          if (dump_ready) ptr <= ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State-decoded outputs.
  always_comb begin
    cpu_rst    = (state == IDLE) || (state == HOLD);
    cpu_clk_en = (state == RUN);
    mem_sel    = (state == RD) || (state == CAP) || (state == OUT);
    mem_addr   = mem_sel ? ptr : '0;
    dump_valid = (state == OUT);
    done       = (state == DONE);
    busy       = (state != IDLE) && (state != DONE);
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Testbench for cpu_run_controller: default-parameter instance for run and
// dump scenarios, plus a RESET_HOLD=0 / empty-window instance.
module tb_cpu_run_controller;

  logic        clk;
  logic        rstb;
  logic        start, halt, dump_ready;
  logic [31:0] cycle_limit;
  logic        cpu_rst, cpu_clk_en, mem_sel, dump_valid, busy, done, timeout;
  logic [9:0]  mem_addr, dump_addr;
  logic [31:0] mem_rd_data, dump_data, cycles_run;

  logic        start2, halt2, dump_ready2;
  logic [31:0] cycle_limit2;
  logic        cpu_rst2, cpu_clk_en2, mem_sel2, dump_valid2, busy2, done2, timeout2;
  logic [9:0]  mem_addr2, dump_addr2;
  logic [31:0] mem_rd_data2, dump_data2, cycles_run2;

  logic [31:0] mem [0:1023];
  int tests = 0;
  int fails = 0;

  cpu_run_controller dut (
    .clk(clk), .rstb(rstb), .start(start), .cycle_limit(cycle_limit), .halt(halt),
    .cpu_rst(cpu_rst), .cpu_clk_en(cpu_clk_en), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data), .busy(busy), .done(done),
    .timeout(timeout), .cycles_run(cycles_run)
  );

  cpu_run_controller #(.RESET_HOLD(0), .DUMP_START(4), .DUMP_STOP(4)) dut2 (
    .clk(clk), .rstb(rstb), .start(start2), .cycle_limit(cycle_limit2), .halt(halt2),
    .cpu_rst(cpu_rst2), .cpu_clk_en(cpu_clk_en2), .mem_sel(mem_sel2), .mem_addr(mem_addr2),
    .mem_rd_data(mem_rd_data2), .dump_valid(dump_valid2), .dump_ready(dump_ready2),
    .dump_addr(dump_addr2), .dump_data(dump_data2), .busy(busy2), .done(done2),
    .timeout(timeout2), .cycles_run(cycles_run2)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read memory: data valid one cycle after the address.
  always @(posedge clk) begin
    mem_rd_data  <= mem[mem_addr];
    mem_rd_data2 <= mem[mem_addr2];
  end

  task automatic run_case(input string name, input logic [31:0] limit, input int halt_at,
                          input int ready_pct, input bit spam_start);
    int hold_n = 0, run_n = 0, got = 0, bad = 0, unstable = 0, exp_run;
    logic exp_to, pend = 0, finished = 0;
    logic [9:0] paddr;
    logic [31:0] pdata;
    if (halt_at > 0 && (limit == 0 || halt_at <= int'(limit))) begin
      exp_run = halt_at; exp_to = 0;
    end else begin
      exp_run = int'(limit); exp_to = 1;
    end
    @(negedge clk);
    cycle_limit = limit; start = 1; halt = 0; dump_ready = 0;
    @(negedge clk);
    start = 0;
    for (int c = 0; c < 8000; c++) begin
      if (busy && cpu_rst) hold_n++;
      if (cpu_clk_en) run_n++;
      if (pend && (!dump_valid || dump_addr !== paddr || dump_data !== pdata)) unstable++;
      if (done) begin finished = 1; break; end
      halt = cpu_clk_en && (run_n == halt_at);
      start = spam_start && busy && ($urandom_range(0, 3) == 0);
      dump_ready = ($urandom_range(0, 99) < ready_pct);
      if (dump_valid && dump_ready) begin
        if (dump_addr !== 10'(got) || dump_data !== mem[got]) bad++;
        got++;
        pend = 0;
      end else if (dump_valid) begin
        pend = 1; paddr = dump_addr; pdata = dump_data;
      end else pend = 0;
      @(negedge clk);
    end
    start = 0; halt = 0; dump_ready = 0;
    tests++; if (finished !== 1'b1) begin fails++; $display("FAIL %s done_reached got=%0b want=1", name, finished); end
    tests++; if (hold_n !== 2) begin fails++; $display("FAIL %s hold_cycles got=%0d want=2", name, hold_n); end
    tests++; if (run_n !== exp_run) begin fails++; $display("FAIL %s clk_en_cycles got=%0d want=%0d", name, run_n, exp_run); end
    tests++; if (cycles_run !== 32'(exp_run)) begin fails++; $display("FAIL %s cycles_run got=%0d want=%0d", name, cycles_run, exp_run); end
    tests++; if (timeout !== exp_to) begin fails++; $display("FAIL %s timeout got=%0b want=%0b", name, timeout, exp_to); end
    tests++; if (got !== 256) begin fails++; $display("FAIL %s word_count got=%0d want=256", name, got); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL %s word_content bad=%0d want=0", name, bad); end
    tests++; if (unstable !== 0) begin fails++; $display("FAIL %s stall_stability events=%0d want=0", name, unstable); end
  endtask

  task automatic test_reset();
    rstb = 1;
    repeat (3) @(negedge clk);
    tests++;
    if ({cpu_rst, cpu_clk_en, mem_sel, dump_valid, busy, done, timeout} !== 7'b1000000) begin
      fails++; $display("FAIL reset_flags got=%b want=1000000",
        {cpu_rst, cpu_clk_en, mem_sel, dump_valid, busy, done, timeout});
    end
    tests++;
    if (mem_addr !== 0 || dump_addr !== 0 || dump_data !== 0 || cycles_run !== 0) begin
      fails++; $display("FAIL reset_values got mem_addr=%0d dump_addr=%0d dump_data=%0h cycles=%0d want all 0",
        mem_addr, dump_addr, dump_data, cycles_run);
    end
    rstb = 0;
    @(negedge clk);
  endtask

  task automatic test_done_hold();
    repeat (10) @(negedge clk);
    tests++;
    if (done !== 1 || busy !== 0 || cycles_run !== 100 || timeout !== 1) begin
      fails++; $display("FAIL done_hold got done=%0b busy=%0b cycles=%0d timeout=%0b want 1 0 100 1",
        done, busy, cycles_run, timeout);
    end
  endtask

  task automatic test_mid_reset();
    int seen = 0;
    @(negedge clk); cycle_limit = 0; start = 1;
    @(negedge clk); start = 0;
    for (int c = 0; c < 50 && seen < 5; c++) begin
      if (cpu_clk_en) seen++;
      @(negedge clk);
    end
    rstb = 1;
    @(negedge clk); rstb = 0;
    tests++;
    if (cpu_rst !== 1 || cpu_clk_en !== 0 || busy !== 0 || dump_valid !== 0 || cycles_run !== 0) begin
      fails++; $display("FAIL reset_in_run got rst=%0b en=%0b busy=%0b valid=%0b cycles=%0d want 1 0 0 0 0",
        cpu_rst, cpu_clk_en, busy, dump_valid, cycles_run);
    end
    cycle_limit = 20; start = 1;
    @(negedge clk); start = 0;
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      if (dump_valid) begin seen = 1; break; end
      @(negedge clk);
    end
    tests++; if (seen !== 1) begin fails++; $display("FAIL reach_out got=%0d want=1", seen); end
    rstb = 1;
    @(negedge clk); rstb = 0;
    tests++;
    if (cpu_rst !== 1 || dump_valid !== 0 || mem_sel !== 0 || busy !== 0 || dump_data !== 0) begin
      fails++; $display("FAIL reset_in_out got rst=%0b valid=%0b sel=%0b busy=%0b data=%0h want 1 0 0 0 0",
        cpu_rst, dump_valid, mem_sel, busy, dump_data);
    end
    seen = 0;
    dump_ready = 1;
    repeat (20) begin
      @(negedge clk);
      if (dump_valid || busy) seen++;
    end
    dump_ready = 0;
    tests++; if (seen !== 0) begin fails++; $display("FAIL no_valid_after_reset got=%0d want=0", seen); end
  endtask

  task automatic test_empty_dump();
    int run_n = 0, valid_n = 0, sel_n = 0;
    logic finished = 0, first_en;
    @(negedge clk); cycle_limit2 = 3; start2 = 1; dump_ready2 = 1;
    @(negedge clk); start2 = 0;
    first_en = cpu_clk_en2 & ~cpu_rst2;
    for (int c = 0; c < 50; c++) begin
      if (cpu_clk_en2) run_n++;
      if (dump_valid2) valid_n++;
      if (mem_sel2) sel_n++;
      if (done2) begin finished = 1; break; end
      @(negedge clk);
    end
    tests++; if (first_en !== 1) begin fails++; $display("FAIL no_hold_run got=%0b want=1", first_en); end
    tests++;
    if (finished !== 1 || run_n !== 3 || timeout2 !== 1 || cycles_run2 !== 3) begin
      fails++; $display("FAIL empty_run got done=%0b runs=%0d timeout=%0b cycles=%0d want 1 3 1 3",
        finished, run_n, timeout2, cycles_run2);
    end
    tests++;
    if (valid_n !== 0 || sel_n !== 0) begin
      fails++; $display("FAIL empty_dump got valid=%0d sel=%0d want 0 0", valid_n, sel_n);
    end
  endtask

  initial begin
    start = 0; halt = 0; dump_ready = 0; cycle_limit = 0;
    start2 = 0; halt2 = 0; dump_ready2 = 0; cycle_limit2 = 0;
    rstb = 1;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i * 4);

    test_reset();
    run_case("halt_run", 0, 10, 100, 0);
    run_case("limit_run", 100, 0, 100, 0);
    test_done_hold();
    run_case("halt_limit_tie", 5, 5, 100, 0);
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    run_case("backpressure", 32'($urandom_range(1, 40)), $urandom_range(0, 40), 50, 0);
    run_case("busy_start", 32'($urandom_range(5, 30)), $urandom_range(1, 30), 70, 1);
    run_case("back_to_back", 0, $urandom_range(1, 20), 30, 0);
    test_mid_reset();
    run_case("after_reset", 12, 0, 80, 0);
    test_empty_dump();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_run_controller.md
CPU_RUN_CONTROLLER -- requirements
Module: cpu_run_controller

Interface
REQ-001 The block SHALL have the following parameters:
- N, default 32, memory word width.
- ADDR_W, default 10, memory word-address width.
- CYC_W, default 32, cycle counter width.
- RESET_HOLD, default 2, number of cycles cpu_rst is held after start.
- DUMP_START, default 0, first dumped word address.
- DUMP_STOP, default 256, dump end address (exclusive).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk  input  1  sole clock; all state changes on its rising edge.
- rstb  input  1  synchronous active-high reset.
- start  input  1  single-cycle request to begin a run.
- cycle_limit  input  CYC_W  run length in cycles; 0 = unlimited.
- halt  input  1  CPU halt indication, sampled in RUN.
- cpu_rst  output  1  reset to CPU core.
- cpu_clk_en  output  1  CPU advance enable.
- mem_sel  output  1  1 = controller owns the memory read port.
- mem_addr  output  ADDR_W  read address.
- mem_rd_data  input  N  read data, valid 1 cycle after mem_addr.
- dump_valid  output  1  dump word available.
- dump_ready  input  1  consumer accepts the word.
- dump_addr  output  ADDR_W  address of the dump word.
- dump_data  output  N  dump word.
- busy  output  1  state is not IDLE or DONE.
- done  output  1  run and dump complete.
- timeout  output  1  run ended on cycle_limit rather than halt.
- cycles_run  output  CYC_W  number of RUN cycles executed.

Function
REQ-003 The block SHALL use the states IDLE, HOLD, RUN, RD, CAP, OUT and DONE.
REQ-004 In IDLE, start=1 SHALL clear cycles_run and timeout and move to HOLD; start is ignored in every other state except DONE.
REQ-005 In DONE, start=1 SHALL behave exactly as in IDLE.
REQ-006 HOLD SHALL last exactly RESET_HOLD cycles with cpu_rst=1, then move to RUN; RESET_HOLD=0 SHALL go from IDLE directly to RUN.
REQ-007 cpu_rst SHALL be 1 in IDLE and HOLD and 0 in all other states, so CPU state is preserved during the dump.
REQ-008 cpu_clk_en SHALL be 1 only in RUN.
REQ-009 Each RUN cycle SHALL increment cycles_run; the counter SHALL saturate at all-ones.
REQ-010 RUN SHALL exit when halt=1 (timeout stays 0), or when cycles_run+1==cycle_limit with cycle_limit!=0 (timeout set to 1).
REQ-011 If halt and the limit occur in the same cycle, halt SHALL take priority: timeout=0.
REQ-012 With cycle_limit=0 and no halt, the block SHALL stay in RUN indefinitely.
REQ-013 On RUN exit, the block SHALL move to RD if DUMP_STOP>DUMP_START; otherwise it SHALL go to DONE.
REQ-014 The dump pointer SHALL initialise to DUMP_START.
REQ-015 mem_sel SHALL be 1 in RD, CAP and OUT.
REQ-016 RD SHALL drive mem_addr=pointer.
REQ-017 CAP SHALL register mem_rd_data into dump_data and the pointer into dump_addr.
REQ-018 OUT SHALL assert dump_valid.
REQ-019 dump_valid, dump_data and dump_addr SHALL remain stable until dump_ready=1.
REQ-020 On acceptance, the pointer SHALL increment and the block SHALL go to RD, or to DONE if pointer+1==DUMP_STOP.
REQ-021 Minimum dump throughput SHALL be one word per 3 cycles.
REQ-022 Pointer arithmetic SHALL be ADDR_W bits and SHALL NOT wrap before DUMP_STOP (DUMP_STOP<=2^ADDR_W is required).
REQ-023 dump_ready while dump_valid=0 SHALL be ignored.
REQ-024 done SHALL be 1 only in DONE; busy SHALL be 1 in HOLD, RUN, RD, CAP and OUT.
REQ-025 cycles_run and timeout SHALL hold their values in DONE until the next start.

Reset
REQ-026 rstb=1 at any clock edge, including mid-RUN or mid-dump, SHALL force IDLE.
REQ-027 Reset values: cpu_rst=1; cpu_clk_en=0; mem_sel=0; mem_addr=0; dump_valid=0; dump_addr=0; dump_data=0; busy=0; done=0; timeout=0; cycles_run=0; internal counters 0.
REQ-028 An in-flight dump word SHALL be discarded on reset, with no further dump_valid.

Verification
REQ-029 Halt run: RESET_HOLD=2, limit=0, start, halt on 10th RUN cycle -> cpu_rst high exactly 2 cycles after start, cycles_run=10, timeout=0.
REQ-030 Limit run: limit=100, halt=0 -> exactly 100 cycles of cpu_clk_en=1, cycles_run=100, timeout=1.
REQ-031 Full dump: DUMP_START=0, DUMP_STOP=256, memory word i = i*4, dump_ready=1 -> 256 words, addresses 0..255 in order with matching data, then done=1.
REQ-032 Backpressure: dump_ready toggles randomly -> no word lost or duplicated, and dump_data is stable while dump_valid=1 and dump_ready=0.
REQ-033 Mid-operation reset: rstb=1 during RUN and, separately, during OUT -> next cycle IDLE, cpu_rst=1, dump_valid=0; a new start runs normally.
REQ-034 Corner cases: halt coincides with limit=5 -> timeout=0; DUMP_STOP=DUMP_START -> DONE with no dump_valid; start asserted while busy -> no effect.
